// File: rtl/cell_painter_pkg.sv
// Shared types and geometry helpers for the cell painter and its raster sweep.
package cell_painter_pkg;

   typedef enum logic [1:0] {
      MODE_PAINT = 2'b00,
      MODE_ERASE = 2'b01,
      MODE_CLEAR = 2'b10,
      MODE_RSVD  = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SWEEP,
      ST_DONE
   } state_e;

   function automatic int cells_x(input int screen_width, input int cell_width);
      return screen_width / cell_width;
   endfunction

   function automatic int cells_y(input int screen_height, input int cell_width);
      return screen_height / cell_width;
   endfunction

endpackage

// File: rtl/cell_painter_if.sv
// Command/plot bundle between the cell front end (master) and the painter (slave).
interface cell_painter_if #(
   parameter int COLOUR_BITS = 9,
   parameter int BW          = 2,
   parameter int XW          = 10,
   parameter int YW          = 9
);
   logic                   iReq;
   logic [1:0]             iMode;
   logic [7:0]             iX_cell;
   logic [7:0]             iY_cell;
   logic [BW-1:0]          iBrush;
   logic [COLOUR_BITS-1:0] iColour;
   logic [COLOUR_BITS-1:0] iBgColour;
   logic [XW-1:0]          oX_pixel;
   logic [YW-1:0]          oY_pixel;
   logic [COLOUR_BITS-1:0] oColour;
   logic                   oPlot;
   logic                   oBusy;
   logic                   oDone;

   modport master (
      output iReq, iMode, iX_cell, iY_cell, iBrush, iColour, iBgColour,
      input  oX_pixel, oY_pixel, oColour, oPlot, oBusy, oDone
   );

   modport slave (
      input  iReq, iMode, iX_cell, iY_cell, iBrush, iColour, iBgColour,
      output oX_pixel, oY_pixel, oColour, oPlot, oBusy, oDone
   );
endinterface

// File: rtl/cell_painter_raster_sweep.sv
// Rectangle raster walker: load a pixel box, then advance one pixel per step, x fastest.
module raster_sweep #(
   parameter int XW = 10,
   parameter int YW = 9
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_load,
   input  logic          i_step,
   input  logic [XW-1:0] i_x0,
   input  logic [XW-1:0] i_x1,
   input  logic [YW-1:0] i_y0,
   input  logic [YW-1:0] i_y1,
   output logic [XW-1:0] o_x,
   output logic [YW-1:0] o_y,
   output logic          o_last
);

   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   logic [XW-1:0] r_x0;
   logic [XW-1:0] r_x1;
   logic [YW-1:0] r_y1;
   logic          w_x_end;

   assign w_x_end = (r_x == r_x1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_x  <= '0;
         r_y  <= '0;
         r_x0 <= '0;
         r_x1 <= '0;
         r_y1 <= '0;
      end else if (i_load) begin
         r_x  <= i_x0;
         r_y  <= i_y0;
         r_x0 <= i_x0;
         r_x1 <= i_x1;
         r_y1 <= i_y1;
      end else if (i_step) begin
         if (w_x_end) begin
            r_x <= r_x0;
            r_y <= r_y + 1'b1;
         end else begin
            r_x <= r_x + 1'b1;
         end
      end
   end

   assign o_x    = r_x;
   assign o_y    = r_y;
   assign o_last = w_x_end && (r_y == r_y1);

endmodule

// File: rtl/cell_painter.sv
// Brush/erase/clear drawing engine feeding the vga_adapter plot port, one pixel per clock.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | waiting for iReq; command fields latched on acceptance
//   ST_SETUP | clamped pixel box computed; sweep loaded or empty stroke skipped
//   ST_SWEEP | one plot per clock in raster order until the last pixel
//   ST_DONE  | one-cycle oDone pulse, then back to idle
module cell_painter
   import cell_painter_pkg::*;
#(
   parameter int SCREEN_WIDTH  = 320,
   parameter int SCREEN_HEIGHT = 240,
   parameter int CELL_WIDTH    = 5,
   parameter int COLOUR_BITS   = 9,
   parameter int MAX_BRUSH     = 3,
   parameter int BW            = $clog2(MAX_BRUSH + 1)
) (
   input  logic           iClk,
   input  logic           iResetn,
   cell_painter_if.slave  bus
);

   localparam int CELLS_X = cells_x(SCREEN_WIDTH, CELL_WIDTH);
   localparam int CELLS_Y = cells_y(SCREEN_HEIGHT, CELL_WIDTH);
   localparam int XW      = $clog2(SCREEN_WIDTH) + 1;
   localparam int YW      = $clog2(SCREEN_HEIGHT) + 1;

   localparam logic [BW-1:0] MAX_B   = BW'(MAX_BRUSH);
   localparam logic [9:0]    CX_MAX  = 10'(CELLS_X - 1);
   localparam logic [9:0]    CY_MAX  = 10'(CELLS_Y - 1);
   localparam logic [9:0]    CX_LIM  = 10'(CELLS_X);
   localparam logic [9:0]    CY_LIM  = 10'(CELLS_Y);

   state_e                 r_state;
   mode_e                  r_mode;
   logic [7:0]             r_cx;
   logic [7:0]             r_cy;
   logic [BW-1:0]          r_brush;
   logic [COLOUR_BITS-1:0] r_colour;
   logic [COLOUR_BITS-1:0] r_colour_out;
   logic                   r_plot;
   logic                   r_busy;
   logic                   r_done;

   logic [9:0]        w_cx_ext;
   logic [9:0]        w_cy_ext;
   logic [9:0]        w_br_ext;
   logic signed [9:0] w_cx_lo;
   logic signed [9:0] w_cy_lo;
   logic [9:0]        w_cx_hi;
   logic [9:0]        w_cy_hi;
   logic [9:0]        w_cx0;
   logic [9:0]        w_cx1;
   logic [9:0]        w_cy0;
   logic [9:0]        w_cy1;
   logic [XW-1:0]     w_x0;
   logic [XW-1:0]     w_x1;
   logic [YW-1:0]     w_y0;
   logic [YW-1:0]     w_y1;
   logic              w_empty;
   logic              w_load;
   logic              w_step;
   logic              w_last;
   logic [XW-1:0]     w_x;
   logic [YW-1:0]     w_y;

   // Signed low bound so a brush hanging off the top/left edge clamps to 0 instead of wrapping.
   always_comb begin
      w_cx_ext = {2'b00, r_cx};
      w_cy_ext = {2'b00, r_cy};
      w_br_ext = 10'(r_brush);
      w_cx_lo  = $signed(w_cx_ext) - $signed(w_br_ext);
      w_cy_lo  = $signed(w_cy_ext) - $signed(w_br_ext);
      w_cx_hi  = w_cx_ext + w_br_ext;
      w_cy_hi  = w_cy_ext + w_br_ext;
      w_cx0    = w_cx_lo[9] ? '0 : w_cx_lo;
      w_cy0    = w_cy_lo[9] ? '0 : w_cy_lo;
      w_cx1    = (w_cx_hi > CX_MAX) ? CX_MAX : w_cx_hi;
      w_cy1    = (w_cy_hi > CY_MAX) ? CY_MAX : w_cy_hi;
      w_empty  = 1'b0;
      if (r_mode == MODE_CLEAR) begin
         w_x0 = '0;
         w_y0 = '0;
         w_x1 = XW'(SCREEN_WIDTH - 1);
         w_y1 = YW'(SCREEN_HEIGHT - 1);
      end else begin
         w_x0    = XW'(16'(w_cx0) * 16'(CELL_WIDTH));
         w_y0    = YW'(16'(w_cy0) * 16'(CELL_WIDTH));
         w_x1    = XW'((16'(w_cx1) + 16'd1) * 16'(CELL_WIDTH) - 16'd1);
         w_y1    = YW'((16'(w_cy1) + 16'd1) * 16'(CELL_WIDTH) - 16'd1);
         w_empty = (w_cx_ext >= CX_LIM) || (w_cy_ext >= CY_LIM);
      end
   end

   assign w_load = (r_state == ST_SETUP) && !w_empty;
   assign w_step = (r_state == ST_SWEEP) && !w_last;

   raster_sweep #(
      .XW (XW),
      .YW (YW)
   ) u_sweep (
      .i_clk   (iClk),
      .i_rst_n (iResetn),
      .i_load  (w_load),
      .i_step  (w_step),
      .i_x0    (w_x0),
      .i_x1    (w_x1),
      .i_y0    (w_y0),
      .i_y1    (w_y1),
      .o_x     (w_x),
      .o_y     (w_y),
      .o_last  (w_last)
   );

   always_ff @(posedge iClk or negedge iResetn) begin
      if (!iResetn) begin
         r_state      <= ST_IDLE;
         r_mode       <= MODE_PAINT;
         r_cx         <= '0;
         r_cy         <= '0;
         r_brush      <= '0;
         r_colour     <= '0;
         r_colour_out <= '0;
         r_plot       <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.iReq && (mode_e'(bus.iMode) != MODE_RSVD)) begin
                  r_mode   <= mode_e'(bus.iMode);
                  r_cx     <= bus.iX_cell;
                  r_cy     <= bus.iY_cell;
                  r_brush  <= (bus.iBrush > MAX_B) ? MAX_B : bus.iBrush;
                  r_colour <= (mode_e'(bus.iMode) == MODE_PAINT) ? bus.iColour : bus.iBgColour;
                  r_busy   <= 1'b1;
                  r_state  <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (w_empty) begin
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_plot       <= 1'b1;
                  r_colour_out <= r_colour;
                  r_state      <= ST_SWEEP;
               end
            end
            ST_SWEEP: begin
               if (w_last) begin
                  r_plot  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.oX_pixel = w_x;
   assign bus.oY_pixel = w_y;
   assign bus.oColour  = r_colour_out;
   assign bus.oPlot    = r_plot;
   assign bus.oBusy    = r_busy;
   assign bus.oDone    = r_done;

endmodule

// File: tb/tb_cell_painter.sv
// Directed bench for cell_painter: command table with hand-computed pixel boxes plus reset corner cases.
module tb_cell_painter;
   import cell_painter_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cell_painter_if #(.COLOUR_BITS(9), .BW(2), .XW(10), .YW(9)) bus ();

   cell_painter #(
      .SCREEN_WIDTH  (320),
      .SCREEN_HEIGHT (240),
      .CELL_WIDTH    (5),
      .COLOUR_BITS   (9),
      .MAX_BRUSH     (3)
   ) dut (
      .iClk    (clk),
      .iResetn (rst_n),
      .bus     (bus)
   );

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      logic [1:0] mode;
      int         cx;
      int         cy;
      int         br;
      logic [8:0] col;
      logic [8:0] bg;
      int         n;
      int         x0;
      int         x1;
      int         y0;
      int         y1;
      logic [8:0] ecol;
      int         poke;
   } vec_t;

   localparam int NV = 8;
   vec_t vecs [NV];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.iMode     = v.mode;
      bus.iX_cell   = 8'(v.cx);
      bus.iY_cell   = 8'(v.cy);
      bus.iBrush    = 2'(v.br);
      bus.iColour   = v.col;
      bus.iBgColour = v.bg;
   endtask

   task automatic run_cmd(input vec_t v, input bit skip_wait, input string tag);
      int plots, first_k, done_k, dones, idle_k, coord_err, col_err, ex, ey, lx, ly;
      plots = 0; first_k = -1; done_k = -1; dones = 0; idle_k = -1;
      coord_err = 0; col_err = 0; ex = v.x0; ey = v.y0; lx = -1; ly = -1;
      if (!skip_wait) @(negedge clk);
      drive(v);
      bus.iReq = 1'b1;
      @(posedge clk); #1;
      bus.iReq = 1'b0;
      check({tag, "_busy_E0"}, int'(bus.oBusy), 1);
      for (int k = 1; k <= v.n + 10; k++) begin
         @(posedge clk); #1;
         if (bus.iReq) bus.iReq = 1'b0;
         if (bus.oPlot) begin
            if (plots == 0) first_k = k;
            if (int'(bus.oX_pixel) != ex || int'(bus.oY_pixel) != ey) coord_err++;
            if (bus.oColour != v.ecol) col_err++;
            lx = int'(bus.oX_pixel);
            ly = int'(bus.oY_pixel);
            plots++;
            if (ex == v.x1) begin
               ex = v.x0;
               ey++;
            end else begin
               ex++;
            end
            // mid-sweep request with different fields: must be ignored entirely
            if (plots == v.poke) begin
               bus.iReq      = 1'b1;
               bus.iMode     = 2'b00;
               bus.iColour   = 9'h155;
               bus.iBgColour = 9'h0AA;
               bus.iX_cell   = 8'd3;
               bus.iY_cell   = 8'd3;
               bus.iBrush    = 2'd3;
            end
         end
         if (bus.oDone) begin
            dones++;
            if (done_k < 0) done_k = k;
         end
         if (!bus.oBusy) begin
            idle_k = k;
            break;
         end
      end
      check({tag, "_plots"}, plots, v.n);
      if (v.n > 0) begin
         check({tag, "_first_k"}, first_k, 1);
         check({tag, "_last_x"}, lx, v.x1);
         check({tag, "_last_y"}, ly, v.y1);
         check({tag, "_coord_err"}, coord_err, 0);
         check({tag, "_col_err"}, col_err, 0);
      end
      check({tag, "_done_k"}, done_k, v.n + 1);
      check({tag, "_dones"}, dones, 1);
      check({tag, "_idle_k"}, idle_k, v.n + 2);
      @(posedge clk); #1;
      check({tag, "_quiet"}, int'({bus.oPlot, bus.oBusy, bus.oDone}), 0);
   endtask

   initial begin
      vec_t vr, vm;
      int   cnt;

      //          mode   cx  cy  br  col     bg      n      x0   x1   y0   y1   ecol    poke
      vecs[0] = '{2'b00, 10, 5,  0,  9'h1C0, 9'h000, 25,    50,  54,  25,  29,  9'h1C0, 10};
      vecs[1] = '{2'b00, 0,  0,  1,  9'h0A5, 9'h000, 100,   0,   9,   0,   9,   9'h0A5, -1};
      vecs[2] = '{2'b00, 63, 47, 3,  9'h03F, 9'h000, 400,   300, 319, 220, 239, 9'h03F, 200};
      vecs[3] = '{2'b01, 20, 10, 1,  9'h1C0, 9'h003, 225,   95,  109, 45,  59,  9'h003, -1};
      vecs[4] = '{2'b00, 64, 0,  0,  9'h1C0, 9'h000, 0,     0,   0,   0,   0,   9'h000, -1};
      vecs[5] = '{2'b00, 0,  48, 2,  9'h1C0, 9'h000, 0,     0,   0,   0,   0,   9'h000, -1};
      vecs[6] = '{2'b00, 1,  1,  2,  9'h111, 9'h000, 400,   0,   19,  0,   19,  9'h111, 399};
      vecs[7] = '{2'b10, 7,  7,  0,  9'h012, 9'h1FF, 76800, 0,   319, 0,   239, 9'h1FF, 1000};

      vr = '{2'b00, 2, 2, 0, 9'h0F0, 9'h000, 25, 10, 14, 10, 14, 9'h0F0, -1};
      vm = '{2'b00, 0, 0, 1, 9'h0CC, 9'h000, 100, 0, 9, 0, 9, 9'h0CC, -1};

      bus.iReq = 1'b0;
      drive(vr);
      bus.iReq = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check("rst_flags", int'({bus.oPlot, bus.oBusy, bus.oDone}), 0);
         check("rst_xy", int'(bus.oX_pixel) + int'(bus.oY_pixel), 0);
         check("rst_colour", int'(bus.oColour), 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_cmd(vr, 1'b1, "rst_release");

      for (int i = 0; i < NV; i++) run_cmd(vecs[i], 1'b0, $sformatf("vec%0d", i));

      @(negedge clk);
      bus.iMode = 2'b11;
      bus.iReq  = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         check("rsvd_busy", int'(bus.oBusy), 0);
         check("rsvd_plot", int'(bus.oPlot), 0);
      end
      bus.iReq = 1'b0;

      @(negedge clk);
      drive(vm);
      bus.iReq = 1'b1;
      @(posedge clk); #1;
      bus.iReq = 1'b0;
      cnt = 0;
      for (int k = 0; k < 200; k++) begin
         @(posedge clk); #1;
         if (bus.oPlot) cnt++;
         if (cnt == 40) break;
      end
      check("midrst_reach40", cnt, 40);
      rst_n = 1'b0;
      #1;
      check("midrst_plot", int'(bus.oPlot), 0);
      check("midrst_busy", int'(bus.oBusy), 0);
      check("midrst_done", int'(bus.oDone), 0);
      check("midrst_x", int'(bus.oX_pixel), 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_cmd(vr, 1'b0, "after_midrst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
